// File: rtl/fbcpu_pkg.sv
// fbcpu_pkg: shared FB-CPU constants, ISA opcodes and the RAM init-sequencer state encoding.
package fbcpu_pkg;

  localparam int FBCPU_DATA_W = 10;
  localparam int FBCPU_ADDR_W = 6;

  localparam logic [3:0] OP_LOD = 4'b0000;
  localparam logic [3:0] OP_STO = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JMZ = 4'b0111;
  localparam logic [3:0] OP_HLT = 4'b1001;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } init_state_e;

endpackage

// File: rtl/fbcpu_ram_init_seq.sv
// fbcpu_ram_init_seq: after every reset sweeps addresses 0..DEPTH-1 once,
// driving the RAM's internal clear port, then parks in RUN with busy low.
module fbcpu_ram_init_seq
  import fbcpu_pkg::*;
#(
  parameter int ADDR_W = FBCPU_ADDR_W,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  init_state_e       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and sweep counter; reset always restarts the sweep at address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear one word per cycle; leaving INIT on the last word makes busy exactly DEPTH cycles long.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    init_we   = 1'b0;
    init_addr = cnt;
    case (state)
      ST_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: rtl/fbcpu_ram2p.sv
// fbcpu_ram2p: two-port synchronous RAM for the FB-CPU. Port A is the CPU
// datapath port, port B a request/grant loader port that loses same-address
// write collisions. Define FBCPU_RAM_BYPASS_EN to forward a same-cycle write
// from one port to a read of the same address on the other port.
module fbcpu_ram2p
  import fbcpu_pkg::*;
#(
  parameter int                DATA_W     = FBCPU_DATA_W,
  parameter int                ADDR_W     = FBCPU_ADDR_W,
  parameter int                DEPTH      = 64,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              a_in_range;
  logic              b_in_range;
  logic              same_addr;
  logic              a_wr_en;
  logic              b_wr_en;
  logic              b_rd_en;
  logic [DATA_W-1:0] a_rd_word;
  logic [DATA_W-1:0] b_rd_word;

  fbcpu_ram_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign a_ready = !busy;

  // Grant, write enables and read words; out-of-range addresses read as zero and never write.
  always_comb begin
    a_in_range = {1'b0, a_addr} < DEPTH_L;
    b_in_range = {1'b0, b_addr} < DEPTH_L;
    same_addr  = (a_addr == b_addr);
    b_gnt      = b_req && !busy && !(a_we && b_we && same_addr);
    a_wr_en    = !busy && a_we && a_in_range;
    b_wr_en    = b_gnt && b_we && b_in_range;
    b_rd_en    = b_gnt && !b_we;
    a_rd_word  = '0;
    b_rd_word  = '0;
    if (a_in_range) begin
      a_rd_word = mem[a_addr];
    end
    if (b_in_range) begin
      b_rd_word = mem[b_addr];
    end
`ifdef FBCPU_RAM_BYPASS_EN
    if (b_wr_en && same_addr) begin
      a_rd_word = b_wdata;
    end
    if (a_wr_en && same_addr) begin
      b_rd_word = a_wdata;
    end
`endif
  end

  // Storage array: the init sweep owns it while busy, otherwise both ports may write.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VALUE;
    end else begin
      if (a_wr_en) begin
        mem[a_addr] <= a_wdata;
      end
      if (b_wr_en) begin
        mem[b_addr] <= b_wdata;
      end
    end
  end

  // Read registers: A reads every RUN cycle, B only on a granted read; both hold while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      b_rvalid <= b_rd_en;
      if (!busy) begin
        a_rdata <= a_rd_word;
      end
      if (b_rd_en) begin
        b_rdata <= b_rd_word;
      end
    end
  end

endmodule

// File: tb/tb_fbcpu_ram2p.sv
// tb_fbcpu_ram2p: randomized and directed bench for fbcpu_ram2p against an
// array-based behavioural model; a second DEPTH=48 instance covers out-of-range access.
module tb_fbcpu_ram2p;

  localparam int DW    = 10;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

`ifdef FBCPU_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          busy, a_ready, b_gnt, b_rvalid;
  logic          a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata;

  logic          d48_busy, d48_a_ready, d48_b_gnt, d48_b_rvalid;
  logic          d48_a_we = 1'b0, d48_b_req = 1'b0, d48_b_we = 1'b0;
  logic [AW-1:0] d48_a_addr = '0, d48_b_addr = '0;
  logic [DW-1:0] d48_a_wdata = '0, d48_b_wdata = '0;
  logic [DW-1:0] d48_a_rdata, d48_b_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fbcpu_ram2p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_VALUE('0)) dut (
    .clk(clk), .rst(rst), .busy(busy), .a_ready(a_ready),
    .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  fbcpu_ram2p #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48), .INIT_VALUE('0)) dut48 (
    .clk(clk), .rst(rst), .busy(d48_busy), .a_ready(d48_a_ready),
    .a_we(d48_a_we), .a_addr(d48_a_addr), .a_wdata(d48_a_wdata), .a_rdata(d48_a_rdata),
    .b_req(d48_b_req), .b_we(d48_b_we), .b_addr(d48_b_addr), .b_wdata(d48_b_wdata),
    .b_gnt(d48_b_gnt), .b_rvalid(d48_b_rvalid), .b_rdata(d48_b_rdata)
  );

  // Behavioural model: a word array, a countdown of clear cycles left, and the expected read registers.
  logic [DW-1:0] model [DEPTH];
  int            init_left = DEPTH;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic          m_v = 1'b0;
  logic          exp_gnt;

  assign exp_gnt = (init_left == 0) && b_req && !(a_we && b_we && (a_addr == b_addr));

  // Advance the model one clock using the access rules; reset restarts the clear countdown.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_left <= DEPTH;
      m_a <= '0;
      m_b <= '0;
      m_v <= 1'b0;
    end else if (init_left != 0) begin
      model[DEPTH - init_left] <= '0;
      init_left <= init_left - 1;
      m_v <= 1'b0;
    end else begin
      m_a <= (BYPASS && exp_gnt && b_we && (b_addr == a_addr)) ? b_wdata : model[a_addr];
      if (a_we) model[a_addr] <= a_wdata;
      if (exp_gnt && b_we) model[b_addr] <= b_wdata;
      m_v <= exp_gnt && !b_we;
      if (exp_gnt && !b_we)
        m_b <= (BYPASS && a_we && (a_addr == b_addr)) ? a_wdata : model[b_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle out of reset, compare all DUT outputs with the model away from the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, init_left != 0});
      checkOutput("a_ready", {31'd0, a_ready}, {31'd0, init_left == 0});
      checkOutput("b_gnt", {31'd0, b_gnt}, {31'd0, exp_gnt});
      checkOutput("a_rdata", {22'd0, a_rdata}, {22'd0, m_a});
      checkOutput("b_rvalid", {31'd0, b_rvalid}, {31'd0, m_v});
      checkOutput("b_rdata", {22'd0, b_rdata}, {22'd0, m_b});
    end
  end

  task automatic applyStimulus(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic br, input logic bw, input logic [AW-1:0] ba,
                               input logic [DW-1:0] bd);
    a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
  endtask

  task automatic apply48(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd);
    d48_a_we = aw; d48_a_addr = aa; d48_a_wdata = ad;
    d48_b_req = br; d48_b_we = bw; d48_b_addr = ba; d48_b_wdata = bd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomStimulus(input int addr_max);
    applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, addr_max)), DW'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, addr_max)), DW'($urandom));
  endtask

  task automatic waitInit(input string name);
    int cyc = 0;
    while (busy && cyc < 200) begin
      randomStimulus(63);
      tick();
      cyc++;
    end
    checkOutput(name, 32'(cyc), 32'd64);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [AW-1:0] ld_addr [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd50, 6'd51};
  logic [DW-1:0] ld_data [6] = '{10'h032, 10'h0B3, 10'h074, 10'h240, 10'h005, 10'h00A};

  initial begin
    $display("[TB] start, bypass=%0d", BYPASS);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("rst_a_rdata", {22'd0, a_rdata}, 32'd0);
    checkOutput("rst_b_rdata", {22'd0, b_rdata}, 32'd0);
    checkOutput("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    rst = 1'b1;
    waitInit("init_cycles");

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, AW'(i), 0, 0, 0, 0, 0);
      tick();
      checkOutput("init_read", {22'd0, a_rdata}, 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 1, ld_addr[i], ld_data[i]);
      checkOutput("load_gnt", {31'd0, b_gnt}, 32'd1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, ld_addr[i], 0, 0, 0, 0, 0);
      tick();
      checkOutput("load_readback", {22'd0, a_rdata}, {22'd0, ld_data[i]});
    end

    applyStimulus(1, 6'd52, 10'h00F, 1, 1, 6'd52, 10'h1FF);
    checkOutput("ww_collision_gnt", {31'd0, b_gnt}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 6'd52, 10'h1FF);
    checkOutput("ww_retry_gnt", {31'd0, b_gnt}, 32'd1);
    tick();
    applyStimulus(0, 6'd52, 0, 0, 0, 0, 0);
    tick();
    checkOutput("ww_final", {22'd0, a_rdata}, 32'h1FF);

    applyStimulus(1, 6'd10, 10'h123, 1, 0, 6'd10, 0);
    checkOutput("xrd_gnt", {31'd0, b_gnt}, 32'd1);
    tick();
    checkOutput("xrd_rvalid", {31'd0, b_rvalid}, 32'd1);
    checkOutput("xrd_rdata", {22'd0, b_rdata}, BYPASS ? 32'h123 : 32'h000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("xrd_rvalid_drop", {31'd0, b_rvalid}, 32'd0);

    applyStimulus(1, 6'd5, 10'h3FF, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 6'd3, 0, 1, 0, 6'd2, 0);
    tick();
    checkOutput("pre_rst_a", {22'd0, a_rdata}, 32'h240);
    checkOutput("pre_rst_b", {22'd0, b_rdata}, 32'h074);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd1);
    checkOutput("midrst_a_rdata", {22'd0, a_rdata}, 32'd0);
    checkOutput("midrst_b_rdata", {22'd0, b_rdata}, 32'd0);
    checkOutput("midrst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    waitInit("reinit_cycles");
    applyStimulus(0, 6'd5, 0, 0, 0, 0, 0);
    tick();
    checkOutput("reinit_mem5", {22'd0, a_rdata}, 32'd0);

    for (int i = 0; i < 500; i++) begin
      randomStimulus((i < 250) ? 7 : 63);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    apply48(0, 0, 0, 1, 1, 6'd5, 10'h1AB);
    checkOutput("d48_wr_gnt", {31'd0, d48_b_gnt}, 32'd1);
    tick();
    apply48(0, 0, 0, 1, 0, 6'd5, 0);
    tick();
    checkOutput("d48_rd5_valid", {31'd0, d48_b_rvalid}, 32'd1);
    checkOutput("d48_rd5_data", {22'd0, d48_b_rdata}, 32'h1AB);
    apply48(1, 6'd60, 10'h2AA, 0, 0, 0, 0);
    tick();
    apply48(0, 6'd60, 0, 1, 0, 6'd60, 0);
    tick();
    checkOutput("d48_oor_valid", {31'd0, d48_b_rvalid}, 32'd1);
    checkOutput("d48_oor_b_rdata", {22'd0, d48_b_rdata}, 32'd0);
    checkOutput("d48_oor_a_rdata", {22'd0, d48_a_rdata}, 32'd0);
    for (int i = 0; i < 48; i++) begin
      apply48(0, AW'(i), 0, 0, 0, 0, 0);
      tick();
      checkOutput("d48_inrange", {22'd0, d48_a_rdata}, (i == 5) ? 32'h1AB : 32'd0);
    end
    apply48(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fbcpu_ram2p.md
Name: fbcpu_ram2p

Overview:
- Parametrised two-port synchronous RAM for the FB-CPU; next generation of the single-port 10-bit/64-word program/data memory.
- Port A serves the CPU datapath (fetch, LOD, STO); port B is a request/grant loader/debug port, so test programs are written at run time instead of being compiled in.
- A built-in init sequencer clears the array after every reset.

Parameters:
- DATA_W, 10, word width (4-bit opcode + 6-bit operand in the base ISA)
- ADDR_W, 6, address width of both ports
- DEPTH, 64, number of words; DEPTH <= 2**ADDR_W
- INIT_VALUE, 0, word written to every location by the init sequencer

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- busy  output  1  init sweep in progress
- a_ready  output  1  port A accepts accesses (= !busy)
- a_we  input  1  port A write enable
- a_addr  input  ADDR_W  port A address
- a_wdata  input  DATA_W  port A write data
- a_rdata  output  DATA_W  port A read data, 1-cycle latency
- b_req  input  1  port B request
- b_we  input  1  port B write (0 = read)
- b_addr  input  ADDR_W  port B address
- b_wdata  input  DATA_W  port B write data
- b_gnt  output  1  port B request accepted this cycle (combinational)
- b_rvalid  output  1  port B read data valid
- b_rdata  output  DATA_W  port B read data

Behaviour:
- Reset (rst=0, async): busy=1, a_rdata=0, b_rdata=0, b_rvalid=0, init counter=0. Array contents are not reset.
- FSM states INIT and RUN; reset enters INIT.
- INIT: writes INIT_VALUE to address cnt each cycle, cnt 0..DEPTH-1. After writing DEPTH-1 the FSM goes to RUN; busy falls on the next edge, so the sweep takes exactly DEPTH cycles after reset release.
- In INIT, a_we and b_req are ignored, b_gnt=0, and a_rdata/b_rdata hold.
- Reset asserted mid-INIT or mid-RUN restarts INIT from address 0.
- Port A in RUN, every cycle:
  - a_rdata <= mem[a_addr] on every edge (reads always on).
  - If a_we, mem[a_addr] <= a_wdata.
  - Same-port read-during-write returns the OLD word.
- Port B grant: b_gnt = b_req && !busy && !(a_we && b_we && a_addr==b_addr).
  - A write-write collision to the same address: port A wins, B is stalled (b_gnt=0) and must hold its request.
  - A B read colliding with an A write is granted.
- Port B granted write: mem[b_addr] <= b_wdata.
- Port B granted read: b_rdata <= mem[b_addr] and b_rvalid=1 the next cycle only.
  - b_rvalid is 0 in every other cycle; b_rdata holds its last value.
- Cross-port read of a word written the same cycle by the other port returns the OLD word (unless the optional feature below is enabled).
- Out-of-range address (addr >= DEPTH): writes are dropped; reads return 0 (b_rvalid still pulses).
- Both ports are fully pipelined: one access per port per cycle, no bubbles.

Optional Feature:
- Macro FBCPU_RAM_BYPASS_EN.
- Defined: any read (either port) to an address written in the same cycle by the other port returns the new write data. Same-port read-during-write still returns OLD data.
- Undefined: cross-port reads return OLD data as above.

Decomposition:
- Package fbcpu_pkg holds:
  - opcode constants OP_LOD=4'b0000, OP_STO=4'b0001, OP_ADD=4'b0010, OP_SUB=4'b0011, OP_MUL=4'b0100, OP_JMP=4'b0110, OP_JMZ=4'b0111, OP_HLT=4'b1001
  - FBCPU_DATA_W=10, FBCPU_ADDR_W=6
  - init FSM state encoding.
- One sub-module, fbcpu_ram_init_seq: INIT/RUN FSM plus address counter. It drives the internal write port during INIT and produces busy.

Test Plan:
- Reset release -> busy=1 for exactly 64 cycles, then 0. Read every address on port A -> 0x000. b_gnt=0 throughout INIT.
- Load via B: 0->0x032, 1->0x0B3, 2->0x074, 3->0x240, 50->0x005, 51->0x00A. Read back on port A -> each value one cycle after address; b_gnt=1 on every write.
- Same cycle, A writes 52<-0x00F and B writes 52<-0x1FF -> b_gnt=0 that cycle. B retries next cycle and is granted; final mem[52]=0x1FF.
- Port A writes 10<-0x123 while B reads 10 -> b_rdata=old value (0x000), or 0x123 with FBCPU_RAM_BYPASS_EN. b_rvalid pulses for 1 cycle.
- Assert rst mid-RUN after loading 0x3FF at address 5 -> outputs return to 0 immediately, busy=1. After 64 cycles mem[5]=0x000.
- DEPTH=48, ADDR_W=6: write 60<-0x2AA on A, read 60 on B -> b_rdata=0x000, b_rvalid=1; addresses 0..47 unaffected.
